// File: rtl/ctech_clk_branch_sel_ctl.sv
// rtl/ctech_clk_branch_sel_ctl.sv - break-before-make enable sequencer for two gated clock branches
//
// Drives the enables of two clock-gate cells whose outputs are merged downstream.
// The enables are never high together. Every hand-over or shutdown from an enabled
// branch holds both enables low for exactly DEAD_CYC full clk cycles.
//
// Ports:
//   clk            block clock
//   rst            synchronous active-high reset
//   req_valid      branch-select request valid
//   req_branch     requested branch: 0=none, 1=branch1, 2=branch2, 3=illegal
//   req_ready      request accepted on this edge if req_valid (IDLE/ON and no force_off)
//   force_off      emergency shutdown of both branches, overrides requests
//   en1, en2       registered clock-gate enables
//   active_branch  registered branch currently enabled (0 when none)
//   busy           high while both enables are held off in the dead gap
//   sel_done       one-cycle pulse when a request completes
//   err_illegal    one-cycle pulse when a branch-3 request is accepted

module ctech_clk_branch_sel_ctl #(
    parameter int DEAD_CYC = 2,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_branch,
    output logic       req_ready,
    input  logic       force_off,
    output logic       en1,
    output logic       en2,
    output logic [1:0] active_branch,
    output logic       busy,
    output logic       sel_done,
    output logic       err_illegal
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [1:0]       BR_NONE   = 2'd0;
    localparam logic [1:0]       BR_ILL    = 2'd3;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       tgt_q, tgt_d;
    logic             forced_q, forced_d;
    logic [1:0]       act_d;
    logic             done_d;
    logic             err_d;
    logic             accept;
    logic [1:0]       dead_tgt;
    logic             dead_forced;

    assign req_ready = ((state_q == ST_IDLE) || (state_q == ST_ON)) && !force_off;
    assign accept    = req_valid && req_ready;

    // force_off seen during the gap replaces the pending target but keeps the count
    assign dead_tgt    = force_off ? BR_NONE : tgt_q;
    assign dead_forced = forced_q || force_off;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tgt_d    = tgt_q;
        forced_d = forced_q;
        act_d    = active_branch;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    done_d = 1'b1;
                    if (req_branch == BR_ILL) begin
                        err_d = 1'b1;
                    end else if (req_branch != BR_NONE) begin
                        // IDLE is only reached after a full gap or reset, so enable at once
                        act_d   = req_branch;
                        state_d = ST_ON;
                    end
                end
            end

            ST_ON: begin
                if (force_off) begin
                    act_d    = BR_NONE;
                    tgt_d    = BR_NONE;
                    forced_d = 1'b1;
                    cnt_d    = DEAD_LOAD;
                    state_d  = ST_DEAD;
                end else if (accept) begin
                    if (req_branch == BR_ILL) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else if (req_branch == active_branch) begin
                        done_d = 1'b1;
                    end else begin
                        act_d    = BR_NONE;
                        tgt_d    = req_branch;
                        forced_d = 1'b0;
                        cnt_d    = DEAD_LOAD;
                        state_d  = ST_DEAD;
                    end
                end
            end

            ST_DEAD: begin
                tgt_d    = dead_tgt;
                forced_d = dead_forced;
                if (cnt_q <= CNT_ONE) begin
                    // last gap cycle: counter reaches 0 and the target takes over
                    cnt_d    = '0;
                    act_d    = dead_tgt;
                    state_d  = (dead_tgt == BR_NONE) ? ST_IDLE : ST_ON;
                    done_d   = !dead_forced;
                    tgt_d    = BR_NONE;
                    forced_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                tgt_d    = BR_NONE;
                forced_d = 1'b0;
                act_d    = BR_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            tgt_q         <= BR_NONE;
            forced_q      <= 1'b0;
            en1           <= 1'b0;
            en2           <= 1'b0;
            active_branch <= BR_NONE;
            busy          <= 1'b0;
            sel_done      <= 1'b0;
            err_illegal   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tgt_q         <= tgt_d;
            forced_q      <= forced_d;
            // both enables decode from one branch code, so they can never be high together
            en1           <= (act_d == 2'd1);
            en2           <= (act_d == 2'd2);
            active_branch <= act_d;
            busy          <= (state_d == ST_DEAD);
            sel_done      <= done_d;
            err_illegal   <= err_d;
        end
    end

endmodule

// File: tb/tb_ctech_clk_branch_sel_ctl.sv
// tb/tb_ctech_clk_branch_sel_ctl.sv - directed and stress bench for ctech_clk_branch_sel_ctl
module tb_ctech_clk_branch_sel_ctl;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic [1:0] req_branch;
    logic       req_ready;
    logic       force_off;
    logic       en1, en2;
    logic [1:0] active_branch;
    logic       busy, sel_done, err_illegal;

    logic            s_rst;
    logic [1:0]      s_valid;
    logic [1:0][1:0] s_branch;
    logic [1:0]      s_force;
    logic [1:0]      s_ready, s_en1, s_en2, s_busy, s_done, s_err;
    logic [1:0][1:0] s_ab;

    int vec_cnt;
    int err_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ctech_clk_branch_sel_ctl #(.DEAD_CYC(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_branch(req_branch),
        .req_ready(req_ready), .force_off(force_off), .en1(en1), .en2(en2),
        .active_branch(active_branch), .busy(busy), .sel_done(sel_done),
        .err_illegal(err_illegal)
    );

    ctech_clk_branch_sel_ctl #(.DEAD_CYC(1), .CNT_W(4)) dut_d1 (
        .clk(clk), .rst(s_rst), .req_valid(s_valid[0]), .req_branch(s_branch[0]),
        .req_ready(s_ready[0]), .force_off(s_force[0]), .en1(s_en1[0]), .en2(s_en2[0]),
        .active_branch(s_ab[0]), .busy(s_busy[0]), .sel_done(s_done[0]),
        .err_illegal(s_err[0])
    );

    ctech_clk_branch_sel_ctl #(.DEAD_CYC(15), .CNT_W(4)) dut_d15 (
        .clk(clk), .rst(s_rst), .req_valid(s_valid[1]), .req_branch(s_branch[1]),
        .req_ready(s_ready[1]), .force_off(s_force[1]), .en1(s_en1[1]), .en2(s_en2[1]),
        .active_branch(s_ab[1]), .busy(s_busy[1]), .sel_done(s_done[1]),
        .err_illegal(s_err[1])
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic e1, input logic e2,
                             input logic [1:0] ab, input logic bz, input logic dn,
                             input logic er);
        check_val({tag, ".en1"}, en1, e1);
        check_val({tag, ".en2"}, en2, e2);
        check_val({tag, ".active"}, active_branch, ab);
        check_val({tag, ".busy"}, busy, bz);
        check_val({tag, ".sel_done"}, sel_done, dn);
        check_val({tag, ".err"}, err_illegal, er);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic req(input logic [1:0] br);
        req_valid  = 1'b1;
        req_branch = br;
        step();
        req_valid  = 1'b0;
        req_branch = 2'd0;
    endtask

    initial begin : stim
        int run [2];
        logic prev_en [2];
        logic rdy_prev [2];
        int dcyc [2];

        vec_cnt = 0;
        err_cnt = 0;
        rst = 1'b1; req_valid = 1'b0; req_branch = 2'd0; force_off = 1'b0;
        s_rst = 1'b1; s_valid = '0; s_branch = '0; s_force = '0;
        @(negedge clk);
        step();
        step();
        check_out("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        check_val("reset.ready", req_ready, 1);

        // IDLE -> branch1, immediate enable
        req(2'd1);
        check_out("idle_to_1", 1, 0, 1, 0, 1, 0);
        step();
        check_out("on1_settle", 1, 0, 1, 0, 0, 0);

        // 1 -> 2 hand-over with two dead cycles
        req(2'd2);
        check_out("h12_c0", 0, 0, 0, 1, 0, 0);
        check_val("h12_c0.ready", req_ready, 0);
        step();
        check_out("h12_c1", 0, 0, 0, 1, 0, 0);
        check_val("h12_c1.ready", req_ready, 0);
        step();
        check_out("h12_c2", 0, 1, 2, 0, 1, 0);
        check_val("h12_c2.ready", req_ready, 1);
        step();
        check_out("h12_c3", 0, 1, 2, 0, 0, 0);

        // branch2 -> none
        req(2'd0);
        check_out("off_c0", 0, 0, 0, 1, 0, 0);
        step();
        check_out("off_c1", 0, 0, 0, 1, 0, 0);
        step();
        check_out("off_c2", 0, 0, 0, 0, 1, 0);

        // illegal and no-op requests
        req(2'd3);
        check_out("ill_idle", 0, 0, 0, 0, 1, 1);
        req(2'd0);
        check_out("none_idle", 0, 0, 0, 0, 1, 0);
        req(2'd1);
        check_out("idle_to_1b", 1, 0, 1, 0, 1, 0);
        req(2'd3);
        check_out("ill_on", 1, 0, 1, 0, 1, 1);
        req(2'd1);
        check_out("same_on", 1, 0, 1, 0, 1, 0);

        // force_off during a 1 -> 2 gap: target dropped, no reload, no done
        req(2'd2);
        check_out("frc_c0", 0, 0, 0, 1, 0, 0);
        force_off = 1'b1;
        step();
        force_off = 1'b0;
        check_out("frc_c1", 0, 0, 0, 1, 0, 0);
        step();
        check_out("frc_c2", 0, 0, 0, 0, 0, 0);
        check_val("frc_c2.ready", req_ready, 1);
        step();
        check_out("frc_c3", 0, 0, 0, 0, 0, 0);

        // force_off in ON with a pending request: request blocked, shutdown
        req(2'd1);
        check_out("on1_c", 1, 0, 1, 0, 1, 0);
        force_off = 1'b1; req_valid = 1'b1; req_branch = 2'd2;
        #1;
        check_val("fon.ready", req_ready, 0);
        step();
        check_out("fon_c0", 0, 0, 0, 1, 0, 0);
        step();
        check_out("fon_c1", 0, 0, 0, 1, 0, 0);
        step();
        check_out("fon_c2", 0, 0, 0, 0, 0, 0);
        check_val("fon_c2.ready", req_ready, 0);
        step();
        check_out("fon_c3", 0, 0, 0, 0, 0, 0);
        force_off = 1'b0; req_valid = 1'b0; req_branch = 2'd0;
        #1;
        check_val("fon_rel.ready", req_ready, 1);

        // reset mid-DEAD and mid-ON
        req(2'd1);
        req(2'd2);
        check_out("rst_dead_pre", 0, 0, 0, 1, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_out("rst_dead", 0, 0, 0, 0, 0, 0);
        step();
        step();
        check_out("rst_dead_after", 0, 0, 0, 0, 0, 0);
        req(2'd2);
        check_out("on2_pre_rst", 0, 1, 2, 0, 1, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_out("rst_on", 0, 0, 0, 0, 0, 0);

        // random stress on DEAD_CYC=1 and DEAD_CYC=15 instances
        dcyc[0] = 1;
        dcyc[1] = 15;
        for (int i = 0; i < 2; i++) begin
            run[i] = 0; prev_en[i] = 1'b0; rdy_prev[i] = 1'b0;
        end
        step();
        s_rst = 1'b0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                logic any_en;
                logic [1:0] exp_ab;
                any_en = s_en1[i] | s_en2[i];
                exp_ab = s_en1[i] ? 2'd1 : (s_en2[i] ? 2'd2 : 2'd0);
                check_val("s_excl", s_en1[i] & s_en2[i], 0);
                check_val("s_active", s_ab[i], exp_ab);
                if (s_busy[i]) begin
                    check_val("s_busy_off", any_en, 0);
                    run[i]++;
                end else if (run[i] != 0) begin
                    check_val("s_gap_len", run[i], dcyc[i]);
                    run[i] = 0;
                end
                if (prev_en[i] && !any_en)
                    check_val("s_fall_busy", s_busy[i], 1);
                prev_en[i] = any_en;

                if (s_valid[i] && rdy_prev[i])
                    s_valid[i] = 1'b0;
                if (!s_valid[i] && ($urandom % 3 == 0)) begin
                    s_valid[i]  = 1'b1;
                    s_branch[i] = 2'($urandom % 4);
                end
                s_force[i] = ($urandom % 12 == 0);
            end
            #1;
            for (int i = 0; i < 2; i++) rdy_prev[i] = s_ready[i];
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
